// File: rtl/cp0_irq_timer.sv
// cp0_irq_timer: MIPS coprocessor-0 register file with a prescaled Count/Compare
// timer, synchronised hardware interrupts, a registered interrupt request and
// the exception entry vector.
module cp0_irq_timer #(
  parameter int          HW_IRQ_NUM  = 5,
  parameter int          COUNT_DIV   = 2,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           data_i,
  input  logic [HW_IRQ_NUM-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic                  eret_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delayslot_i,
  input  logic                  bad_addr_valid_i,
  input  logic [31:0]           bad_addr_i,
  output logic [31:0]           data_o,
  output logic [31:0]           count_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           ebase_o,
  output logic                  int_req_o,
  output logic [31:0]           exc_vector_o
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_EBASE    = 5'd15;

  // Prescaler is at least one bit wide; with COUNT_DIV = 1 it simply stays 0.
  localparam int          PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_BEV = 22;

  logic [31:0]           count;
  logic [31:0]           compare;
  logic [31:0]           status;
  logic [31:0]           epc;
  logic [31:0]           badvaddr;
  logic [17:0]           ebase_hi;
  logic                  cause_bd;
  logic                  cause_iv;
  logic [4:0]            cause_exc;
  logic [1:0]            ip_sw;
  logic [HW_IRQ_NUM-1:0] ip_hw;
  logic                  timer_pending;
  logic [PW-1:0]         presc;
  logic                  int_req;

  logic [HW_IRQ_NUM-1:0] int_sync;
  logic [4:0]            ip_hw_ext;
  logic [7:0]            ip;
  logic                  tick;
  logic                  wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase;

  assign wr_count   = we_i && (waddr_i == ADDR_COUNT);
  assign wr_compare = we_i && (waddr_i == ADDR_COMPARE);
  assign wr_status  = we_i && (waddr_i == ADDR_STATUS);
  assign wr_cause   = we_i && (waddr_i == ADDR_CAUSE);
  assign wr_epc     = we_i && (waddr_i == ADDR_EPC);
  assign wr_ebase   = we_i && (waddr_i == ADDR_EBASE);

  assign tick = (presc == PRESC_MAX);

  // Interrupt synchroniser chain (bypassed entirely when SYNC_STAGES is 0).
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign int_sync = int_i;
    end else begin : g_sync
      logic [HW_IRQ_NUM-1:0] sync_ff [SYNC_STAGES];
      // Shift the raw interrupt levels through the synchroniser flops.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
        end else begin
          sync_ff[0] <= int_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
        end
      end
      assign int_sync = sync_ff[SYNC_STAGES-1];
    end
  endgenerate

  // Zero-extend the hardware IP field to its five Cause positions.
  always_comb begin
    ip_hw_ext = 5'b0;
    ip_hw_ext[HW_IRQ_NUM-1:0] = ip_hw;
  end

  assign ip = {timer_pending, ip_hw_ext, ip_sw};

  // Count and its prescaler; an mtc0 to Count beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'h0000_0000;
      presc <= '0;
    end else if (wr_count) begin
      count <= data_i;
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + PRESC_ONE;
      if (tick) count <= count + 32'd1;
    end
  end

  // Compare register and the sticky timer-pending flag (a Compare write clears it).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare       <= 32'hFFFF_FFFF;
      timer_pending <= 1'b0;
    end else if (wr_compare) begin
      compare       <= data_i;
      timer_pending <= 1'b0;
    end else if (count == compare) begin
      timer_pending <= 1'b1;
    end
  end

  // Status, Cause, EPC, BadVAddr, EBase: mtc0 first, then exception/eret override.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status    <= 32'h0040_0000;
      epc       <= 32'h0000_0000;
      badvaddr  <= 32'h0000_0000;
      ebase_hi  <= EBASE_RESET[29:12];
      cause_bd  <= 1'b0;
      cause_iv  <= 1'b0;
      cause_exc <= 5'd0;
      ip_sw     <= 2'b00;
      ip_hw     <= '0;
    end else begin
      ip_hw <= int_sync;
      if (wr_status) status <= data_i;
      if (wr_epc) epc <= data_i;
      if (wr_ebase) ebase_hi <= data_i[29:12];
      if (wr_cause) begin
        cause_iv <= data_i[23];
        ip_sw    <= data_i[9:8];
      end
      if (exc_valid_i) begin
        status[STATUS_EXL] <= 1'b1;
        cause_exc          <= exc_code_i;
        if (!status[STATUS_EXL]) begin
          epc      <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
          cause_bd <= in_delayslot_i;
        end
        if (bad_addr_valid_i) badvaddr <= bad_addr_i;
      end else if (eret_i) begin
        status[STATUS_EXL] <= 1'b0;
      end
    end
  end

  // Registered interrupt request from enabled, unmasked pending lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_req <= 1'b0;
    end else begin
      int_req <= status[STATUS_IE] & ~status[STATUS_EXL] & (|(ip & status[15:8]));
    end
  end

  assign count_o   = count;
  assign status_o  = status;
  assign cause_o   = {cause_bd, 7'b0, cause_iv, 7'b0, ip, 1'b0, cause_exc, 2'b00};
  assign epc_o     = epc;
  assign ebase_o   = {2'b10, ebase_hi, 12'h000};
  assign int_req_o = int_req;

  assign exc_vector_o = status[STATUS_BEV] ? 32'hBFC0_0380 : (ebase_o + 32'h0000_0180);

  // Read mux over current register state; unmapped addresses read zero.
  always_comb begin
    data_o = 32'h0000_0000;
    case (raddr_i)
      ADDR_BADVADDR: data_o = badvaddr;
      ADDR_COUNT:    data_o = count;
      ADDR_COMPARE:  data_o = compare;
      ADDR_STATUS:   data_o = status;
      ADDR_CAUSE:    data_o = cause_o;
      ADDR_EPC:      data_o = epc;
      ADDR_EBASE:    data_o = ebase_o;
      default:       data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Self-checking bench for cp0_irq_timer: register table plus timer, interrupt,
// exception and collision sequences. A second instance runs COUNT_DIV = 1 with
// no synchroniser.
module tb_cp0_irq_timer;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [4:0]  int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic        eret_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic        bad_addr_valid_i;
  logic [31:0] bad_addr_i;

  logic [31:0] data_o, count_o, status_o, cause_o, epc_o, ebase_o, exc_vector_o;
  logic        int_req_o;
  logic [31:0] data1, count1, status1, cause1, epc1, ebase1, vec1;
  logic        int_req1;

  int n_cmp;
  int n_err;

  cp0_irq_timer #(.HW_IRQ_NUM(5), .COUNT_DIV(2), .SYNC_STAGES(2), .EBASE_RESET(32'h8000_0000)) u_dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i), .data_i(data_i),
    .int_i(int_i), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .eret_i(eret_i),
    .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .bad_addr_valid_i(bad_addr_valid_i),
    .bad_addr_i(bad_addr_i), .data_o(data_o), .count_o(count_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .ebase_o(ebase_o), .int_req_o(int_req_o),
    .exc_vector_o(exc_vector_o)
  );

  cp0_irq_timer #(.HW_IRQ_NUM(5), .COUNT_DIV(1), .SYNC_STAGES(0), .EBASE_RESET(32'h8000_0000)) u_dut1 (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i), .data_i(data_i),
    .int_i(int_i), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .eret_i(eret_i),
    .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .bad_addr_valid_i(bad_addr_valid_i),
    .bad_addr_i(bad_addr_i), .data_o(data1), .count_o(count1), .status_o(status1),
    .cause_o(cause1), .epc_o(epc1), .ebase_o(ebase1), .int_req_o(int_req1),
    .exc_vector_o(vec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] val);
    we_i = 1'b1; waddr_i = addr; data_i = val;
    tick();
    we_i = 1'b0;
  endtask

  task automatic raise_exc(input logic [31:0] pc, input logic ds, input logic [4:0] code);
    exc_valid_i = 1'b1; pc_i = pc; in_delayslot_i = ds; exc_code_i = code;
    tick();
    exc_valid_i = 1'b0; in_delayslot_i = 1'b0; bad_addr_valid_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; raddr_i = 5'd9; data_i = 32'h0;
    int_i = 5'b0; exc_valid_i = 1'b0; exc_code_i = 5'd0; eret_i = 1'b0; pc_i = 32'h0;
    in_delayslot_i = 1'b0; bad_addr_valid_i = 1'b0; bad_addr_i = 32'h0;

    vecs[0]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd11, 32'hFFFF_FFFF};
    vecs[1]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd12, 32'h0040_0000};
    vecs[2]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd13, 32'h0000_0000};
    vecs[3]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd14, 32'h0000_0000};
    vecs[4]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd15, 32'h8000_0000};
    vecs[5]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd8,  32'h0000_0000};
    vecs[6]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd3,  32'h0000_0000};
    vecs[7]  = '{1'b1, 5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
    vecs[8]  = '{1'b1, 5'd15, 32'hFFFF_FFFF, 5'd15, 32'hBFFF_F000};
    vecs[9]  = '{1'b1, 5'd15, 32'h8000_0000, 5'd15, 32'h8000_0000};
    vecs[10] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0080_0300};
    vecs[11] = '{1'b1, 5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
    vecs[12] = '{1'b1, 5'd3,  32'h0000_0005, 5'd3,  32'h0000_0000};
    vecs[13] = '{1'b1, 5'd11, 32'h0000_1000, 5'd11, 32'h0000_1000};
    vecs[14] = '{1'b1, 5'd12, 32'h0040_0000, 5'd12, 32'h0040_0000};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_count_read", data_o, 32'h0000_0000);
    check("rst_count1", count1, 32'h0000_0000);
    check("rst_vector", exc_vector_o, 32'hBFC0_0380);
    check("rst_int_req", {31'b0, int_req_o}, 32'h0);

    // Register table: optional write, then readback through data_o.
    for (int i = 0; i < 15; i++) begin
      we_i = vecs[i].we; waddr_i = vecs[i].waddr; data_i = vecs[i].wdata; raddr_i = vecs[i].raddr;
      tick();
      we_i = 1'b0;
      check($sformatf("vec%0d", i), data_o, vecs[i].exp);
    end

    // data_o shows the pre-write value during the write cycle.
    raddr_i = 5'd14; we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hAAAA_0000;
    #1;
    check("no_bypass", data_o, 32'h1234_5678);
    tick();
    we_i = 1'b0;
    check("epc_after_write", data_o, 32'hAAAA_0000);

    // Timer: Count = 10, Compare = 13, COUNT_DIV = 2.
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd13);
    mtc0(5'd9, 32'd10);
    check("count_load", count_o, 32'd10);
    repeat (5) tick();
    check("count_5cyc", count_o, 32'd12);
    tick();
    check("count_6cyc", count_o, 32'd13);
    check("ip7_not_yet", {31'b0, cause_o[15]}, 32'h0);
    tick();
    check("ip7_set", {31'b0, cause_o[15]}, 32'h1);
    mtc0(5'd12, 32'h0000_8001);
    check("timer_req_lat", {31'b0, int_req_o}, 32'h0);
    tick();
    check("timer_req", {31'b0, int_req_o}, 32'h1);
    mtc0(5'd11, 32'd100);
    check("ip7_clear", {31'b0, cause_o[15]}, 32'h0);
    check("req_hold", {31'b0, int_req_o}, 32'h1);
    tick();
    check("req_drop", {31'b0, int_req_o}, 32'h0);

    // Hardware interrupt line 0 through two synchroniser stages.
    mtc0(5'd12, 32'h0000_0401);
    int_i = 5'b00001;
    tick();
    check("ip2_nosync", {31'b0, cause1[10]}, 32'h1);
    tick();
    check("ip2_2cyc", {31'b0, cause_o[10]}, 32'h0);
    tick();
    check("ip2_3cyc", {31'b0, cause_o[10]}, 32'h1);
    check("hw_req_3cyc", {31'b0, int_req_o}, 32'h0);
    tick();
    check("hw_req_4cyc", {31'b0, int_req_o}, 32'h1);
    raise_exc(32'h8000_0100, 1'b0, 5'd0);
    check("exc_exl", {31'b0, status_o[1]}, 32'h1);
    check("exc_epc", epc_o, 32'h8000_0100);
    tick();
    check("exl_masks_req", {31'b0, int_req_o}, 32'h0);
    int_i = 5'b0;
    eret_i = 1'b1; tick(); eret_i = 1'b0;
    check("eret_exl", status_o, 32'h0000_0401);

    // Delay-slot exception with BadVAddr, then a nested one.
    bad_addr_valid_i = 1'b1; bad_addr_i = 32'h1234_5679;
    raise_exc(32'h8000_1004, 1'b1, 5'd5);
    raddr_i = 5'd8;
    #1;
    check("ds_epc", epc_o, 32'h8000_1000);
    check("ds_bd", {31'b0, cause_o[31]}, 32'h1);
    check("ds_code", {27'b0, cause_o[6:2]}, 32'd5);
    check("badvaddr", data_o, 32'h1234_5679);
    raise_exc(32'h8000_2000, 1'b0, 5'd3);
    check("nested_epc", epc_o, 32'h8000_1000);
    check("nested_bd", {31'b0, cause_o[31]}, 32'h1);
    check("nested_code", {27'b0, cause_o[6:2]}, 32'd3);

    // Collisions.
    eret_i = 1'b1; tick(); eret_i = 1'b0;
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0;
    raise_exc(32'h8000_3000, 1'b0, 5'd4);
    we_i = 1'b0;
    check("mtc0_vs_exc", status_o, 32'h0000_0002);
    check("mtc0_vs_exc_epc", epc_o, 32'h8000_3000);
    eret_i = 1'b1;
    raise_exc(32'h8000_4000, 1'b0, 5'd4);
    eret_i = 1'b0;
    check("eret_vs_exc", {31'b0, status_o[1]}, 32'h1);
    mtc0(5'd9, 32'd5);
    check("count_wr_wins", count1, 32'd5);
    check("count_wr_wins0", count_o, 32'd5);
    tick();
    check("count_div1_inc", count1, 32'd6);
    mtc0(5'd9, 32'hFFFF_FFFF);
    check("count_max", count1, 32'hFFFF_FFFF);
    tick();
    check("count_wrap", count1, 32'h0000_0000);

    // Vector with BEV = 0.
    mtc0(5'd12, 32'h0000_0000);
    check("vec_bev0", exc_vector_o, 32'h8000_0180);
    mtc0(5'd15, 32'h8001_2000);
    check("vec_ebase", exc_vector_o, 32'h8001_2180);

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", count1, 32'h0000_0000);
    check("async_rst_status", status_o, 32'h0040_0000);
    check("async_rst_ebase", ebase_o, 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
